// File: rtl/uart_rx_ovs.sv
// rtl/uart_rx_ovs.sv - 16x oversampling UART receiver with runtime frame format and FWFT FIFO
`timescale 1ns/1ps
module uart_rx_ovs #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_dbits,
  input  logic              cfg_par_en,
  input  logic              cfg_par_odd,
  input  logic              cfg_stop2,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_perr,
  output logic              rd_ferr,
  output logic              rd_brk,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       cnt,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic              busy
);
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_PUSH
  } state_t;
  state_t state, state_nxt;

  logic              sync1, sync2, hist;
  logic [DIV_W-1:0]  pre, div_s;
  logic [3:0]        os;
  logic              s7, s8;
  logic [1:0]        dbits_s;
  logic              par_en_s, par_odd_s, stop2_s;
  logic [DATA_W-1:0] data_r;
  logic [2:0]        bit_idx;
  logic              par_bit, perr_r, ferr_r, brk;
  logic              start_edge, tick, mid, bit_end, maj, last_bit, push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign start_edge = hist & ~sync2;
  assign tick       = (pre == div_s);
  assign mid        = tick && (os == 4'd9);
  assign bit_end    = tick && (os == 4'd15);
  // third vote is the live line value at the count-9 tick
  assign maj        = (s7 & s8) | (s7 & sync2) | (s8 & sync2);
  assign last_bit   = (bit_idx == 3'(dbits_s) + 3'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_edge) state_nxt = S_START;
      S_START:  if (mid && maj) state_nxt = S_IDLE;
                else if (bit_end) state_nxt = S_DATA;
      S_DATA:   if (bit_end && last_bit) state_nxt = par_en_s ? S_PARITY : S_STOP1;
      S_PARITY: if (bit_end) state_nxt = S_STOP1;
      // a good first stop bit with two stops configured waits out the bit
      S_STOP1:  if (mid && !(stop2_s && maj)) state_nxt = S_PUSH;
                else if (bit_end) state_nxt = S_STOP2;
      S_STOP2:  if (mid) state_nxt = S_PUSH;
      S_PUSH:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    push = (state == S_PUSH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre       <= '0;
      os        <= '0;
      s7        <= 1'b1;
      s8        <= 1'b1;
      div_s     <= '0;
      dbits_s   <= '0;
      par_en_s  <= 1'b0;
      par_odd_s <= 1'b0;
      stop2_s   <= 1'b0;
      data_r    <= '0;
      bit_idx   <= '0;
      par_bit   <= 1'b0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
    end else if (state == S_IDLE) begin
      pre <= '0;
      os  <= '0;
      if (start_edge) begin
        div_s     <= cfg_div;
        dbits_s   <= cfg_dbits;
        par_en_s  <= cfg_par_en;
        par_odd_s <= cfg_par_odd;
        stop2_s   <= cfg_stop2;
        data_r    <= '0;
        bit_idx   <= '0;
        par_bit   <= 1'b0;
        perr_r    <= 1'b0;
        ferr_r    <= 1'b0;
      end
    end else begin
      if (tick) begin
        pre <= '0;
        os  <= os + 4'd1;
      end else begin
        pre <= pre + DIV_W'(1);
      end
      if (tick && os == 4'd7) s7 <= sync2;
      if (tick && os == 4'd8) s8 <= sync2;
      if (mid) begin
        case (state)
          S_DATA:   data_r[bit_idx] <= maj;
          S_PARITY: begin
            par_bit <= maj;
            perr_r  <= ((^data_r) ^ maj) != par_odd_s;
          end
          S_STOP1, S_STOP2: if (!maj) ferr_r <= 1'b1;
          default: ;
        endcase
      end
      if (bit_end && state == S_DATA) bit_idx <= bit_idx + 3'd1;
    end
  end

  assign brk = ferr_r && (data_r == '0) && !par_bit;

  logic [DATA_W+2:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_rd, do_wr;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign do_rd = rd_en && !empty;
  assign do_wr = push && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= {brk, ferr_r, perr_r, data_r};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)      cnt <= cnt + (AW+1)'(1);
      else if (!do_wr && do_rd) cnt <= cnt - (AW+1)'(1);
      if (push && !do_wr)   overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  assign {rd_brk, rd_ferr, rd_perr, rd_data} = empty ? '0 : mem[rd_ptr];

endmodule
